player_hand_engine: RTL

PLAYER_HAND_ENGINE -- requirements
Module: player_hand_engine

---
 rtl/player_hand_engine.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/player_hand_engine.sv
// Player hand engine: deals an initial two-card hand on new_round, then draws one
// card per hit edge until stay, bust or a full hand. Aces count 11 and are lowered
// to 1 one at a time whenever the running total would otherwise exceed 21.
module player_hand_engine #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          MAX_CARDS = 11
) (
    input  logic       clk_200Hz,
    input  logic       rst,
    input  logic       new_round,
    input  logic       hit,
    input  logic       stay,
    input  logic       inject_en,
    input  logic [3:0] inject_rank,
    output logic       player_finished,
    output logic [4:0] score,
    output logic [3:0] card_out,
    output logic       bust,
    output logic [3:0] card_count
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_CARDS);

    typedef enum logic [1:0] {IDLE, DRAW, WAIT, DONE} state_t;

    // Result of folding one accepted card into the hand
    typedef struct packed {
        logic [5:0] sum;
        logic [3:0] aces;
    } hand_upd_t;

    state_t     state;
    logic [15:0] lfsr;
    logic [15:0] lfsr_next;
    logic [3:0] unlowered_aces;
    logic [1:0] pending;
    logic       hit_q;
    logic       stay_q;
    logic       hit_rise;
    logic       stay_rise;

    logic       draw_ok;
    logic [3:0] draw_rank;
    logic [3:0] card_val;
    logic [3:0] new_count;
    hand_upd_t  upd;

    assign hit_rise  = hit & ~hit_q;
    assign stay_rise = stay & ~stay_q;
    assign new_count = card_count + 4'd1;
    assign bust      = (score > 5'd21);

    // Galois LFSR, taps 16,14,13,11 (shift right, feedback mask 0xB400)
    assign lfsr_next = {1'b0, lfsr[15:1]} ^ ({16{lfsr[0]}} & 16'hB400);

    // Rank source: injected rank (clamped to K) or the low LFSR nibble when it is a legal rank
    always_comb begin
        draw_ok   = 1'b0;
        draw_rank = 4'd0;
        if (inject_en) begin
            draw_ok   = 1'b1;
            draw_rank = (inject_rank > 4'd12) ? 4'd12 : inject_rank;
        end else if (lfsr[3:0] < 4'd13) begin
            draw_ok   = 1'b1;
            draw_rank = lfsr[3:0];
        end
    end

    // Blackjack value of the candidate rank
    always_comb begin
        if (draw_rank == 4'd0)
            card_val = 4'd11;
        else if (draw_rank <= 4'd8)
            card_val = draw_rank + 4'd1;
        else
            card_val = 4'd10;
    end

    // New total and ace bookkeeping; at most one ace is lowered per card
    always_comb begin
        upd.sum  = {1'b0, score} + {2'b00, card_val};
        upd.aces = unlowered_aces + {3'b000, (draw_rank == 4'd0)};
        if (upd.sum > 6'd21 && upd.aces != 4'd0) begin
            upd.sum  = upd.sum - 6'd10;
            upd.aces = upd.aces - 4'd1;
        end
    end

    // Hand FSM with registered outputs; new_round restarts from any state
    always_ff @(posedge clk_200Hz) begin
        if (rst) begin
            state           <= IDLE;
            lfsr            <= LFSR_SEED;
            score           <= 5'd0;
            card_out        <= 4'd0;
            card_count      <= 4'd0;
            unlowered_aces  <= 4'd0;
            pending         <= 2'd0;
            player_finished <= 1'b0;
            hit_q           <= 1'b0;
            stay_q          <= 1'b0;
        end else begin
            lfsr   <= lfsr_next;
            hit_q  <= hit;
            stay_q <= stay;
            if (new_round) begin
                score           <= 5'd0;
                card_count      <= 4'd0;
                unlowered_aces  <= 4'd0;
                pending         <= 2'd2;
                player_finished <= 1'b0;
                state           <= DRAW;
            end else begin
                case (state)
                    DRAW: begin
                        if (draw_ok) begin
                            card_out       <= draw_rank;
                            card_count     <= new_count;
                            score          <= upd.sum[4:0];
                            unlowered_aces <= upd.aces;
                            pending        <= pending - 2'd1;
                            if (pending > 2'd1) begin
                                state <= DRAW;
                            end else if (upd.sum > 6'd21 || new_count == MAX_CNT) begin
                                state           <= DONE;
                                player_finished <= 1'b1;
                            end else begin
                                state <= WAIT;
                            end
                        end
                    end
                    WAIT: begin
                        if (stay_rise) begin
                            state           <= DONE;
                            player_finished <= 1'b1;
                        end else if (hit_rise) begin
                            pending <= 2'd1;
                            state   <= DRAW;
                        end
                    end
                    default: begin
                        // IDLE and DONE hold everything until new_round
                    end
                endcase
            end
        end
    end

endmodule
